// File: rtl/exm_pipe_buffer.sv
// ============================================================================
// Module      : exm_pipe_buffer
// Description : EX/MEM pipeline buffer with valid/ready handshake, optional
//               2-entry skid register and head-entry forwarding compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exm_pipe_buffer #(
  parameter int DW       = 16,
  parameter int OPW      = 4,
  parameter int RW       = 4,
  parameter int SKID     = 1,
  parameter int ZERO_REG = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           ex_valid,
  output logic           ex_ready,
  input  logic [DW-1:0]  alu_result,
  input  logic [DW-1:0]  alu_remainder,
  input  logic [OPW-1:0] mov_op,
  input  logic [RW-1:0]  reg_rd,
  input  logic           mem_to_reg,
  input  logic           mem_write,
  input  logic           mem_read,
  input  logic           r15,
  input  logic           reg_write,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [DW-1:0]  m_alu_result,
  output logic [DW-1:0]  m_alu_remainder,
  output logic [OPW-1:0] m_mov_op,
  output logic [RW-1:0]  m_reg_rd,
  output logic           m_mem_to_reg,
  output logic           m_mem_write,
  output logic           m_mem_read,
  output logic           m_r15,
  output logic           m_reg_write,
  input  logic [RW-1:0]  fwd_rs,
  input  logic [RW-1:0]  fwd_rt,
  output logic           fwd_rs_hit,
  output logic           fwd_rt_hit
);

  localparam int c_EW = 2*DW + OPW + RW + 5;

  logic [c_EW-1:0] w_in_entry;
  logic [c_EW-1:0] r_head;
  logic            r_head_valid;
  logic            w_accept;
  logic            w_consume;
  logic            w_h_mtr, w_h_mw, w_h_mr, w_h_r15, w_h_rw;
  logic            w_zero_block;

  assign w_in_entry = {alu_result, alu_remainder, mov_op, reg_rd,
                       mem_to_reg, mem_write, mem_read, r15, reg_write};
  assign w_accept   = ex_valid & ex_ready;
  assign w_consume  = r_head_valid & m_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic [c_EW-1:0] r_skid;
      logic            r_skid_valid;
      logic            r_ex_ready;

      // r_ex_ready always mirrors ~r_skid_valid, but from its own flop so
      // EX never sees a combinational path from m_ready.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_head       <= '0;
          r_head_valid <= 1'b0;
          r_skid       <= '0;
          r_skid_valid <= 1'b0;
          r_ex_ready   <= 1'b1;
        end else if (flush) begin
          r_head       <= '0;
          r_head_valid <= 1'b0;
          r_skid       <= '0;
          r_skid_valid <= 1'b0;
          r_ex_ready   <= 1'b1;
        end else if (r_skid_valid) begin
          if (w_consume) begin
            r_head       <= r_skid;
            r_skid_valid <= 1'b0;
            r_ex_ready   <= 1'b1;
          end
        end else if (w_accept) begin
          if (!r_head_valid || w_consume) begin
            r_head       <= w_in_entry;
            r_head_valid <= 1'b1;
          end else begin
            r_skid       <= w_in_entry;
            r_skid_valid <= 1'b1;
            r_ex_ready   <= 1'b0;
          end
        end else if (w_consume) begin
          r_head_valid <= 1'b0;
        end
      end

      assign ex_ready = r_ex_ready;
    end else begin : g_single
      assign ex_ready = m_ready | ~r_head_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_head       <= '0;
          r_head_valid <= 1'b0;
        end else if (flush) begin
          r_head       <= '0;
          r_head_valid <= 1'b0;
        end else if (w_accept) begin
          r_head       <= w_in_entry;
          r_head_valid <= 1'b1;
        end else if (w_consume) begin
          r_head_valid <= 1'b0;
        end
      end
    end
  endgenerate

  assign {m_alu_result, m_alu_remainder, m_mov_op, m_reg_rd,
          w_h_mtr, w_h_mw, w_h_mr, w_h_r15, w_h_rw} = r_head;

  // Control is gated so a bubble can never write memory or the register file.
  assign m_valid      = r_head_valid;
  assign m_mem_to_reg = w_h_mtr & r_head_valid;
  assign m_mem_write  = w_h_mw  & r_head_valid;
  assign m_mem_read   = w_h_mr  & r_head_valid;
  assign m_r15        = w_h_r15 & r_head_valid;
  assign m_reg_write  = w_h_rw  & r_head_valid;

  assign w_zero_block = (ZERO_REG != 0) && (m_reg_rd == '0);
  assign fwd_rs_hit   = m_valid & m_reg_write & (m_reg_rd == fwd_rs) & ~w_zero_block;
  assign fwd_rt_hit   = m_valid & m_reg_write & (m_reg_rd == fwd_rt) & ~w_zero_block;

endmodule

`default_nettype wire
